// File: rtl/scoreboard_pkg.sv
// Shared types for the pipeline scoreboard: in-flight entry layout, default
// readiness stages and the forwarding-select encoding used by the operand muxes.
package scoreboard_pkg;

  localparam int ALU_STAGE_DEF  = 0;
  localparam int LOAD_STAGE_DEF = 2;

  // Entries carry a fixed-width destination so the struct can live here;
  // the scoreboard zero-extends its REG_W-bit indices into it (REG_W <= 8).
  localparam int SB_DEST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic                 load;
    logic [SB_DEST_W-1:0] dest;
  } sb_entry_t;

  // Same encoding as the operand mux select: STD = register file, FWD = bypass.
  typedef enum logic {
    STD = 1'b0,
    FWD = 1'b1
  } fwd_sel_t;

  function automatic fwd_sel_t fwd_sel(input logic hit);
    return hit ? FWD : STD;
  endfunction

  function automatic logic is_producer(input sb_entry_t e);
    return e.valid && e.wen && (e.dest != '0);
  endfunction

endpackage

// File: rtl/sb_match.sv
// Priority encoder for one decode operand: finds the youngest in-flight producer
// of the source register and reports a usable bypass or a stall request.
module sb_match
  import scoreboard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int REG_W      = 5,
  parameter int ALU_STAGE  = ALU_STAGE_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int STG_W      = $clog2(STAGES)
) (
  input  sb_entry_t        entries [STAGES],
  input  logic [REG_W-1:0] src,
  output logic             hit,
  output logic [STG_W-1:0] stage,
  output logic             stall_req
);

  // Walk oldest to youngest so the lowest-index match overwrites everything
  // older; a not-ready youngest match therefore hides any ready older one.
  always_comb begin
    hit       = 1'b0;
    stage     = '0;
    stall_req = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (is_producer(entries[i]) && entries[i].dest == SB_DEST_W'(src)) begin
        hit       = entries[i].load ? (i >= LOAD_STAGE) : (i >= ALU_STAGE);
        stall_req = !hit;
        stage     = hit ? STG_W'(i) : '0;
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// In-flight write tracker beside decode: shadow pipeline of destinations,
// per-operand forwarding/stall resolution, busy bitmap and stall-cycle counter.
module pipe_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int N_SRC      = 2,
  parameter int REG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int ALU_STAGE  = ALU_STAGE_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               adv,
  input  logic                               flush,
  input  logic                               issue_valid,
  input  logic                               issue_wen,
  input  logic                               issue_load,
  input  logic [REG_W-1:0]                   issue_dest,
  input  logic [N_SRC*REG_W-1:0]             src_sel,
  input  logic [STAGES*DATA_W-1:0]           stage_data,
  input  logic                               cnt_clr,
  output logic                               stall,
  output logic [N_SRC-1:0]                   fwd_hit,
  output logic [N_SRC*$clog2(STAGES)-1:0]    fwd_stage,
  output logic [N_SRC*DATA_W-1:0]            fwd_data,
  output logic [2**REG_W-1:0]                busy,
  output logic [CNT_W-1:0]                   stall_cnt
);

  localparam int STG_W = $clog2(STAGES);

  sb_entry_t         entry_reg [STAGES];
  sb_entry_t         issue_entry;
  logic [DATA_W-1:0] stage_arr [STAGES];
  logic [N_SRC-1:0]  stall_req;
  logic              accept;

  genvar gi;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage_data
      assign stage_arr[gi] = stage_data[gi*DATA_W +: DATA_W];
    end

    for (gi = 0; gi < N_SRC; gi++) begin : g_operand
      sb_match #(
        .STAGES     (STAGES),
        .REG_W      (REG_W),
        .ALU_STAGE  (ALU_STAGE),
        .LOAD_STAGE (LOAD_STAGE),
        .STG_W      (STG_W)
      ) u_match (
        .entries   (entry_reg),
        .src       (src_sel[gi*REG_W +: REG_W]),
        .hit       (fwd_hit[gi]),
        .stage     (fwd_stage[gi*STG_W +: STG_W]),
        .stall_req (stall_req[gi])
      );

      assign fwd_data[gi*DATA_W +: DATA_W] =
        fwd_hit[gi] ? stage_arr[fwd_stage[gi*STG_W +: STG_W]] : '0;
    end
  endgenerate

  // Flush overrides any hazard: the decode slot becomes a bubble instead.
  assign stall  = issue_valid && !flush && (|stall_req);
  assign accept = issue_valid && !flush && !stall;

  always_comb begin
    issue_entry       = '0;
    issue_entry.valid = 1'b1;
    issue_entry.wen   = issue_wen;
    issue_entry.load  = issue_load;
    issue_entry.dest  = SB_DEST_W'(issue_dest);
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (is_producer(entry_reg[i])) begin
        busy[entry_reg[i].dest[REG_W-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < STAGES; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (adv) begin
      entry_reg[0] <= accept ? issue_entry : '0;
      for (int i = 1; i < STAGES; i++) begin
        entry_reg[i] <= entry_reg[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && adv && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: a default 3-stage instance and a
// 5-stage / 3-operand / 4-bit-counter instance, with hand-computed expectations.
module tb_pipe_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_adv, a_flush, a_iv, a_wen, a_load, a_cnt_clr;
  logic [4:0]  a_dest;
  logic [9:0]  a_src;
  logic [95:0] a_sd;
  logic        a_stall;
  logic [1:0]  a_hit;
  logic [3:0]  a_fst;
  logic [63:0] a_fdata;
  logic [31:0] a_busy;
  logic [15:0] a_cnt;

  pipe_scoreboard u_dut_a (
    .CLK(clk), .RST(rst), .adv(a_adv), .flush(a_flush), .issue_valid(a_iv),
    .issue_wen(a_wen), .issue_load(a_load), .issue_dest(a_dest), .src_sel(a_src),
    .stage_data(a_sd), .cnt_clr(a_cnt_clr), .stall(a_stall), .fwd_hit(a_hit),
    .fwd_stage(a_fst), .fwd_data(a_fdata), .busy(a_busy), .stall_cnt(a_cnt)
  );

  // Instance B: deeper pipe, later load data, three operands, narrow counter
  logic         b_adv, b_flush, b_iv, b_wen, b_load, b_cnt_clr;
  logic [4:0]   b_dest;
  logic [14:0]  b_src;
  logic [159:0] b_sd;
  logic         b_stall;
  logic [2:0]   b_hit;
  logic [8:0]   b_fst;
  logic [95:0]  b_fdata;
  logic [31:0]  b_busy;
  logic [3:0]   b_cnt;

  pipe_scoreboard #(
    .STAGES(5), .N_SRC(3), .LOAD_STAGE(3), .CNT_W(4)
  ) u_dut_b (
    .CLK(clk), .RST(rst), .adv(b_adv), .flush(b_flush), .issue_valid(b_iv),
    .issue_wen(b_wen), .issue_load(b_load), .issue_dest(b_dest), .src_sel(b_src),
    .stage_data(b_sd), .cnt_clr(b_cnt_clr), .stall(b_stall), .fwd_hit(b_hit),
    .fwd_stage(b_fst), .fwd_data(b_fdata), .busy(b_busy), .stall_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    a_iv  = 1'b0;
    a_src = '0;
    a_adv = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_adv = 0; a_flush = 0; a_iv = 0; a_wen = 0; a_load = 0; a_cnt_clr = 0;
    a_dest = '0; a_src = '0; a_sd = {32'h33, 32'h22, 32'h11};
    b_adv = 0; b_flush = 0; b_iv = 0; b_wen = 0; b_load = 0; b_cnt_clr = 0;
    b_dest = '0; b_src = '0; b_sd = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", a_stall, 0);
    chk("rst_hit",   a_hit,   0);
    chk("rst_fdata", a_fdata, 0);
    chk("rst_busy",  a_busy,  0);
    chk("rst_cnt",   a_cnt,   0);

    // ALU result forwarded from EX
    a_iv = 1; a_wen = 1; a_load = 0; a_dest = 5'd3; a_adv = 1;
    tick();
    a_iv = 0; a_src = 10'd3;
    #1;
    chk("alu_hit",   a_hit,          2'b01);
    chk("alu_stage", a_fst[1:0],     0);
    chk("alu_data",  a_fdata[31:0],  32'h11);
    chk("alu_stall", a_stall,        0);
    chk("alu_busy",  a_busy,         32'h8);
    drain_a();

    // Load-use: two stall cycles, then bypass from stage 2
    a_iv = 1; a_wen = 1; a_load = 1; a_dest = 5'd5;
    tick();
    a_load = 0; a_dest = 5'd6; a_src = 10'd5;
    #1;
    chk("lu_stall0", a_stall, 1);
    chk("lu_hit0",   a_hit,   0);
    chk("lu_busy",   a_busy,  32'h20);
    tick();
    chk("lu_stall1", a_stall, 1);
    tick();
    chk("lu_stall2", a_stall,       0);
    chk("lu_hit2",   a_hit,         2'b01);
    chk("lu_stage2", a_fst[1:0],    2);
    chk("lu_data2",  a_fdata[31:0], 32'h33);
    chk("lu_cnt",    a_cnt,         2);
    drain_a();

    // Two writers of r7: youngest wins
    a_iv = 1; a_wen = 1; a_load = 0; a_dest = 5'd7;
    tick();
    a_iv = 0;
    tick();
    a_iv = 1;
    tick();
    a_iv = 0; a_src = {5'd0, 5'd7}; a_sd = {32'hB, 32'h22, 32'hA};
    #1;
    chk("yw_data",  a_fdata[31:0], 32'hA);
    chk("yw_stage", a_fst[1:0],    0);
    chk("yw_hit",   a_hit,         2'b01);
    a_sd = {32'h33, 32'h22, 32'h11};
    drain_a();

    // Younger unready load shadows an older ready ALU producer
    a_iv = 1; a_wen = 1; a_load = 0; a_dest = 5'd8;
    tick();
    a_load = 1;
    tick();
    a_load = 0; a_dest = 5'd9; a_src = 10'd8;
    #1;
    chk("shadow_stall", a_stall, 1);
    chk("shadow_hit",   a_hit,   0);
    drain_a();

    a_cnt_clr = 1;
    tick();
    a_cnt_clr = 0;
    #1;
    chk("clr_cnt", a_cnt, 0);

    // r0 is never a producer
    a_iv = 1; a_wen = 1; a_load = 0; a_dest = 5'd0;
    tick();
    a_src = 10'd0;
    #1;
    chk("r0_hit",   a_hit,     0);
    chk("r0_stall", a_stall,   0);
    chk("r0_busy0", a_busy[0], 0);
    chk("r0_busy",  a_busy,    0);
    drain_a();

    // Freeze during load-use stall, then flush wins
    a_iv = 1; a_wen = 1; a_load = 1; a_dest = 5'd5;
    tick();
    a_load = 0; a_dest = 5'd6; a_src = 10'd5; a_adv = 0;
    #1;
    chk("frz_stall0", a_stall, 1);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("frz_stall", a_stall, 1);
      chk("frz_cnt",   a_cnt,   0);
      chk("frz_busy",  a_busy,  32'h20);
    end
    a_flush = 1;
    #1;
    chk("fl_stall", a_stall, 0);
    a_adv = 1;
    tick();
    a_flush = 0; a_iv = 0;
    #1;
    chk("fl_busy",  a_busy,  32'h20);
    chk("fl_cnt",   a_cnt,   0);
    chk("fl_stall_idle", a_stall, 0);
    a_iv = 1;
    #1;
    chk("fl_stall_s1", a_stall, 1);
    tick();
    chk("fl_hit_s2",   a_hit,      2'b01);
    chk("fl_stage_s2", a_fst[1:0], 2);
    drain_a();

    // Instance B: load-use lasts 3 cycles on operand 2; counter saturates at 15
    b_adv = 1; b_wen = 1;
    for (int n = 0; n < 6; n++) begin
      b_iv = 1; b_load = 1; b_dest = 5'd9; b_src = '0;
      tick();
      b_load = 0; b_dest = 5'd10; b_src = {5'd9, 10'd0};
      #1;
      for (int j = 0; j < 3; j++) begin
        chk("b_lu_stall", b_stall, 1);
        tick();
      end
      chk("b_lu_release", b_stall,        0);
      chk("b_lu_hit",     b_hit,          3'b100);
      chk("b_lu_stage",   b_fst[8:6],     3);
      chk("b_lu_data",    b_fdata[95:64], 32'h44);
      chk("b_cnt",        b_cnt,          ((3 * (n + 1)) > 15) ? 15 : 3 * (n + 1));
    end

    // Reset mid-stall discards everything on that edge
    b_iv = 1; b_load = 1; b_dest = 5'd9; b_src = '0;
    tick();
    b_load = 0; b_dest = 5'd10; b_src = {5'd9, 10'd0};
    #1;
    chk("b_pre_rst_stall", b_stall, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("b_rst_stall", b_stall, 0);
    chk("b_rst_hit",   b_hit,   0);
    chk("b_rst_busy",  b_busy,  0);
    chk("b_rst_cnt",   b_cnt,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
